// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the multi-port GPR file and its write-merge logic.
package gpr_pkg;

    localparam int GPR_DATA_W   = 16;
    localparam int GPR_NUM_REGS = 8;
    localparam int GPR_ADDR_W   = $clog2(GPR_NUM_REGS);
    localparam int GPR_MAX_WR   = 4;

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
    typedef logic [GPR_DATA_W-1:0] gpr_data_t;

    // Index of the highest-numbered set bit; that write port owns the register.
    function automatic int unsigned gpr_winner(input logic [GPR_MAX_WR-1:0] hits);
        gpr_winner = 0;
        for (int p = 0; p < GPR_MAX_WR; p++) begin
            if (hits[p]) gpr_winner = p;
        end
    endfunction

endpackage

// File: rtl/gpr_wr_merge.sv
// Resolves all write ports per register: hit vector, winning data and same-address conflict.
module gpr_wr_merge import gpr_pkg::*; #(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NUM_REGS = GPR_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [NUM_WR-1:0]                  wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]           wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]           wr_data_i,
    output logic [NUM_REGS-1:0]                hit_o,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    win_data_o,
    output logic                               conflict_o
);

    localparam int PAD_W = GPR_MAX_WR * DATA_W;

    logic [PAD_W-1:0]      data_pad;
    logic [GPR_MAX_WR-1:0] port_hits;

    assign data_pad = PAD_W'(wr_data_i);

    // NOTE: every variable driven here gets a default before any conditional
    // assignment, so no path can leave it holding its old value (no latch).
    always_comb begin
        hit_o      = '0;
        win_data_o = '0;
        conflict_o = 1'b0;
        port_hits  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            port_hits = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                port_hits[p] = wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(r));
            end
            // A hardwired r0 must not be written, clear the scoreboard, or flag conflicts.
            if (ZERO_REG != 0 && r == 0) port_hits = '0;
            hit_o[r]      = |port_hits;
            win_data_o[r] = data_pad[gpr_winner(port_hits)*DATA_W +: DATA_W];
            if ($countones(port_hits) > 1) conflict_o = 1'b1;
        end
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Parametrised multi-port register file with write bypass, optional zero r0 and pending-write scoreboard.
module gpr_file_mp import gpr_pkg::*; #(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NUM_REGS = GPR_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]     wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    output logic [NUM_REGS-1:0]          busy_vec,
    output logic                         wr_conflict,
    output logic [NUM_REGS*DATA_W-1:0]   dbg_regs
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            conflict_q;

    logic [NUM_REGS-1:0]             wr_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0] wr_win;
    logic                            conflict_d;

    gpr_wr_merge #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_wr_merge (
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .hit_o      (wr_hit),
        .win_data_o (wr_win),
        .conflict_o (conflict_d)
    );

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_hit[r]) regs_d[r] = wr_win[r];
            // A new reservation names a newer producer, so it beats a same-cycle write clear.
            if (rsv_en && rsv_addr == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0)) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // NOTE: the storage array sits in flops and is cleared on reset because
    // software relies on every register reading zero after rst, not just r0.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        logic              is_zero;
        logic              fwd;

        assign rd_a    = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (rd_a == '0);
        assign fwd     = (BYPASS != 0) && wr_hit[rd_a];

        assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 : (fwd ? wr_win[rd_a] : regs_q[rd_a]);
        assign rd_busy[k] = !is_zero && busy_q[rd_a] && !fwd;
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;
    assign dbg_regs    = regs_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: two configurations driven in lockstep, checked by table and by an array-based model.
module tb_gpr_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wr_en = '0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [5:0]  rd_addr = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = '0;

    // Config A: bypass on, normal r0.  Config B: bypass off, hardwired-zero r0.
    logic [31:0]  a_rd_data, b_rd_data;
    logic [1:0]   a_rd_busy, b_rd_busy;
    logic [7:0]   a_busy_vec, b_busy_vec;
    logic         a_wr_conflict, b_wr_conflict;
    logic [127:0] a_dbg, b_dbg;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(a_busy_vec),
        .wr_conflict(a_wr_conflict), .dbg_regs(a_dbg)
    );

    gpr_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(b_busy_vec),
        .wr_conflict(b_wr_conflict), .dbg_regs(b_dbg)
    );

    // Reference model: plain arrays updated by the architectural rules.
    logic [15:0] m_regs [2][8];
    logic [7:0]  m_busy [2];
    logic        m_conf [2];

    function automatic bit zr(input int d); return d == 1; endfunction
    function automatic bit bp(input int d); return d == 0; endfunction

    function automatic logic [2:0] wa(input int p); return wr_addr[p*3 +: 3]; endfunction
    function automatic logic [15:0] wd(input int p); return wr_data[p*16 +: 16]; endfunction

    function automatic bit write_hits(input int d, input int a);
        bit h = 0;
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && int'(wa(p)) == a && !(zr(d) && a == 0)) h = 1;
        return h;
    endfunction

    function automatic logic [15:0] exp_rd(input int d, input int a);
        logic [15:0] v = m_regs[d][a];
        if (zr(d) && a == 0) return 16'h0;
        if (bp(d))
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && int'(wa(p)) == a) v = wd(p);  // later port overrides
        return v;
    endfunction

    function automatic logic exp_rb(input int d, input int a);
        if (zr(d) && a == 0) return 1'b0;
        return m_busy[d][a] && !(bp(d) && write_hits(d, a));
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int r = 0; r < 8; r++) m_regs[d][r] = '0;
                m_busy[d] = '0;
                m_conf[d] = 1'b0;
            end else begin
                m_conf[d] = wr_en == 2'b11 && wa(0) == wa(1) && !(zr(d) && wa(0) == 3'd0);
                for (int p = 0; p < 2; p++) begin
                    if (wr_en[p] && !(zr(d) && wa(p) == 3'd0)) begin
                        m_regs[d][wa(p)] = wd(p);
                        m_busy[d][wa(p)] = 1'b0;
                    end
                end
                if (rsv_en && !(zr(d) && rsv_addr == 3'd0)) m_busy[d][rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0]  e_rd;
        logic [1:0]   e_rb;
        logic [127:0] e_dbg;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                e_rd[k*16 +: 16] = exp_rd(d, int'(rd_addr[k*3 +: 3]));
                e_rb[k]          = exp_rb(d, int'(rd_addr[k*3 +: 3]));
            end
            for (int r = 0; r < 8; r++) e_dbg[r*16 +: 16] = m_regs[d][r];
            check($sformatf("%s.%s rd_data", tag, d ? "B" : "A"), d ? b_rd_data : a_rd_data, e_rd);
            check($sformatf("%s.%s rd_busy", tag, d ? "B" : "A"), d ? b_rd_busy : a_rd_busy, e_rb);
            check($sformatf("%s.%s busy_vec", tag, d ? "B" : "A"), d ? b_busy_vec : a_busy_vec, m_busy[d]);
            check($sformatf("%s.%s wr_conflict", tag, d ? "B" : "A"), d ? b_wr_conflict : a_wr_conflict, m_conf[d]);
            check($sformatf("%s.%s dbg_regs", tag, d ? "B" : "A"), d ? b_dbg : a_dbg, e_dbg);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] we,
                         input logic [2:0] wa0, input logic [15:0] wd0,
                         input logic [2:0] wa1, input logic [15:0] wd1,
                         input logic [2:0] ra0, input logic [2:0] ra1,
                         input logic rs, input logic [2:0] rsa);
        @(negedge clk);
        rst      = r;
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rd_addr  = {ra1, ra0};
        rsv_en   = rs;
        rsv_addr = rsa;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [2:0]  wa0;
        logic [15:0] wd0;
        logic [2:0]  wa1;
        logic [15:0] wd1;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic        rsv;
        logic [2:0]  rsva;
        logic [15:0] e_rd_a;
        logic [15:0] e_rd_b;
        logic        e_rb_a;
        logic        e_rb_b;
        logic [7:0]  e_bv_a;
        logic [7:0]  e_bv_b;
        logic        e_cf_a;
        logic        e_cf_b;
    } vec_t;

    vec_t tbl [18];
    logic [127:0] pattern;

    initial begin
        // Expected values are pre-edge (combinational) outputs for each row's inputs.
        tbl[0]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 7, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 3, 5, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{0, 2'b01, 3, 16'hBEEF, 0, 16'h0000, 3, 3, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[3]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 3, 0, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[4]  = '{0, 2'b11, 5, 16'h1111, 5, 16'h2222, 5, 5, 0, 0, 16'h2222, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[5]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 5, 1, 0, 0, 16'h2222, 16'h2222, 0, 0, 8'h00, 8'h00, 1, 1};
        tbl[6]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 5, 1, 0, 0, 16'h2222, 16'h2222, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[7]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2, 2, 1, 2, 16'h0000, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[8]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2, 4, 0, 0, 16'h0000, 16'h0000, 1, 1, 8'h04, 8'h04, 0, 0};
        tbl[9]  = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2, 4, 0, 0, 16'h0000, 16'h0000, 1, 1, 8'h04, 8'h04, 0, 0};
        tbl[10] = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2, 4, 0, 0, 16'h0000, 16'h0000, 1, 1, 8'h04, 8'h04, 0, 0};
        tbl[11] = '{0, 2'b01, 2, 16'h00A5, 0, 16'h0000, 2, 2, 0, 0, 16'h00A5, 16'h0000, 0, 1, 8'h04, 8'h04, 0, 0};
        tbl[12] = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2, 2, 0, 0, 16'h00A5, 16'h00A5, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[13] = '{0, 2'b01, 2, 16'h1234, 0, 16'h0000, 2, 2, 1, 2, 16'h1234, 16'h00A5, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[14] = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2, 2, 0, 0, 16'h1234, 16'h1234, 1, 1, 8'h04, 8'h04, 0, 0};
        tbl[15] = '{0, 2'b01, 0, 16'hFFFF, 0, 16'h0000, 0, 0, 1, 0, 16'hFFFF, 16'h0000, 0, 0, 8'h04, 8'h04, 0, 0};
        tbl[16] = '{0, 2'b11, 0, 16'hFFFF, 0, 16'h0F0F, 0, 0, 0, 0, 16'h0F0F, 16'h0000, 0, 0, 8'h05, 8'h04, 0, 0};
        tbl[17] = '{0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0F0F, 16'h0000, 0, 0, 8'h04, 8'h04, 1, 0};

        // Bring both instances out of their power-up state.
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].ra0, tbl[i].ra1, tbl[i].rsv, tbl[i].rsva);
            check_all($sformatf("row%0d", i));
            check($sformatf("row%0d A rd0", i), a_rd_data[15:0], tbl[i].e_rd_a);
            check($sformatf("row%0d B rd0", i), b_rd_data[15:0], tbl[i].e_rd_b);
            check($sformatf("row%0d A rd_busy0", i), a_rd_busy[0], tbl[i].e_rb_a);
            check($sformatf("row%0d B rd_busy0", i), b_rd_busy[0], tbl[i].e_rb_b);
            check($sformatf("row%0d A busy_vec", i), a_busy_vec, tbl[i].e_bv_a);
            check($sformatf("row%0d B busy_vec", i), b_busy_vec, tbl[i].e_bv_b);
            check($sformatf("row%0d A wr_conflict", i), a_wr_conflict, tbl[i].e_cf_a);
            check($sformatf("row%0d B wr_conflict", i), b_wr_conflict, tbl[i].e_cf_b);
            advance();
        end

        // Fill with index pattern, reserve r1..r4, then reset with a concurrent write and reservation.
        for (int i = 0; i < 8; i += 2) begin
            drive(0, 2'b11, 3'(i), 16'(i), 3'(i + 1), 16'(i + 1), 0, 1, 0, 0);
            check_all($sformatf("fill%0d", i));
            advance();
        end
        for (int i = 1; i <= 4; i++) begin
            drive(0, 2'b00, 0, 0, 0, 0, 3'(i), 7, 1, 3'(i));
            check_all($sformatf("rsv%0d", i));
            advance();
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1, 4, 0, 0);
        for (int r = 0; r < 8; r++) pattern[r*16 +: 16] = 16'(r);
        check("prefill A dbg_regs", a_dbg, pattern);
        check("prefill A busy_vec", a_busy_vec, 128'h1E);
        check("prefill B busy_vec", b_busy_vec, 128'h1E);
        advance();
        drive(1, 2'b11, 3, 16'hAAAA, 6, 16'h5555, 3, 6, 1, 5);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 3, 6, 0, 0);
        check_all("post_rst");
        check("post_rst A dbg_regs", a_dbg, 128'h0);
        check("post_rst B dbg_regs", b_dbg, 128'h0);
        check("post_rst A busy_vec", a_busy_vec, 128'h0);
        check("post_rst B busy_vec", b_busy_vec, 128'h0);
        check("post_rst A rd_data", a_rd_data, 128'h0);
        advance();

        // Randomized traffic; narrow address draws make collisions common.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
            check_all($sformatf("rnd%0d", n));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
